hazard_scoreboard: RTL and testbench

- Parametrised hazard and forwarding unit for the pipelined core.
- Replaces the fixed RA/WA match bus and its fixed 2-source, E/M/W-only decode with a tag pipeline that tracks in-flight register writes.
- Tracks writes across DEPTH post-decode stages, for NSRC source operands, each producer with its own ready stage (ALU vs. load vs. future multi-cycle ops).
- Drives stall/flush controls combinationally and the execute-stage forward selects as registered outputs; also counts stall cycles for performance analysis.

---
 rtl/hazard_pkg.sv | 34 +++
 rtl/hazard_scoreboard_if.sv | 38 +++
 rtl/hazard_tag_pipe.sv | 54 +++++
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard / forwarding unit.
// Slot fields are sized for the largest supported configuration so that one
// packed struct serves every parameterisation (NREG <= 256, DEPTH <= 15).
package hazard_pkg;

  localparam int REG_W_MAX = 8;
  localparam int SEL_W_MAX = 4;
  localparam int DEPTH_MAX = (1 << SEL_W_MAX) - 1;

  // Forward-select value meaning "take the operand from the register file".
  localparam int FWD_RF   = 0;
  // Typical producer ready slots: ALU results leave E, loads leave M.
  localparam int RDY_ALU  = 2;
  localparam int RDY_LOAD = 3;

  // One in-flight writer: valid, destination register, first forwardable slot.
  typedef struct packed {
    logic                 v;
    logic [REG_W_MAX-1:0] wa;
    logic [SEL_W_MAX-1:0] rdy;
  } slot_t;

  // Youngest-writer priority search. hit[k-1] flags a match in slot k.
  // Returns the smallest matching k (1-based), or 0 when nothing matches.
  function automatic logic [SEL_W_MAX-1:0] youngest_match(input logic [DEPTH_MAX-1:0] hit);
    logic [SEL_W_MAX-1:0] idx;
    idx = '0;
    for (int k = DEPTH_MAX - 1; k >= 0; k--) begin
      if (hit[k]) idx = SEL_W_MAX'(k + 1);
    end
    return idx;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode/execute-side handshake between the pipeline and the hazard unit.
interface hazard_scoreboard_if #(
  parameter int NREG  = 16,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int CW    = 16
);
  localparam int REGW = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);

  logic                 IssueD;
  logic                 RegWriteD;
  logic [REGW-1:0]      WA3D;
  logic [SELW-1:0]      ReadyD;
  logic [NSRC*REGW-1:0] RAD;
  logic [NSRC-1:0]      RAUseD;
  logic                 BranchTakenE;
  logic                 PCSrcW;

  logic                 StallF;
  logic                 StallD;
  logic                 FlushD;
  logic                 FlushE;
  logic [NSRC*SELW-1:0] ForwardE;
  logic [CW-1:0]        StallCount;

  // Pipeline side: presents the decode instruction and branch events.
  modport master (
    output IssueD, RegWriteD, WA3D, ReadyD, RAD, RAUseD, BranchTakenE, PCSrcW,
    input  StallF, StallD, FlushD, FlushE, ForwardE, StallCount
  );

  // Hazard unit side.
  modport slave (
    input  IssueD, RegWriteD, WA3D, ReadyD, RAD, RAUseD, BranchTakenE, PCSrcW,
    output StallF, StallD, FlushD, FlushE, ForwardE, StallCount
  );
endinterface

// File: rtl/hazard_tag_pipe.sv
// DEPTH-slot shift register of in-flight writer tags. Slot 1 (index 0) is
// loaded from decode, or with a bubble when E is flushed; later slots shift
// unconditionally because downstream stages never stall.
module hazard_tag_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  slot_t                 in_slot,
  output slot_t [DEPTH-1:0]     slots
);

  logic [DEPTH-1:0]     v_q;
  logic [REG_W_MAX-1:0] wa_q  [DEPTH];
  logic [SEL_W_MAX-1:0] rdy_q [DEPTH];

  // Valid bits advance one slot per edge; flush turns the new entry into a bubble.
  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its neighbour's pre-edge value and the shift does not collapse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else begin
      v_q[0] <= in_slot.v & ~flush;
      for (int k = 1; k < DEPTH; k++) v_q[k] <= v_q[k-1];
    end
  end

  // Payload shifts alongside the valid bits.
  // NOTE: the payload is deliberately left out of reset; it is ignored
  // whenever its valid bit is clear, so resetting it would only add fan-out.
  always_ff @(posedge clk) begin
    wa_q[0]  <= in_slot.wa;
    rdy_q[0] <= in_slot.rdy;
    for (int k = 1; k < DEPTH; k++) begin
      wa_q[k]  <= wa_q[k-1];
      rdy_q[k] <= rdy_q[k-1];
    end
  end

  // Reassemble the slots into one flat packed vector.
  always_comb begin
    slots = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slots[k].v   = v_q[k];
      slots[k].wa  = wa_q[k];
      slots[k].rdy = rdy_q[k];
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Parametrised hazard and forwarding unit. Tracks in-flight register writes
// in a tag pipeline, stalls decode on a not-yet-ready producer, drives the
// flush controls and registers per-operand forward selects for execute.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NREG  = 16,
  parameter int DEPTH = 3,
  parameter int NSRC  = 2,
  parameter int CW    = 16
) (
  input logic              clk,
  input logic              reset,
  hazard_scoreboard_if.slave hz
);

  localparam int REGW = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);

  slot_t [DEPTH-1:0]    slots;
  slot_t                in_slot;
  logic                 load_stall;
  logic                 flush_e;
  logic [NSRC-1:0]      hazard;
  logic [NSRC*SELW-1:0] fwd;
  logic [NSRC*SELW-1:0] forward_q;
  logic [CW-1:0]        stall_count_q;

  // The writeback slot is carried for completeness but never searched: the
  // register file writes on the falling edge, so decode already sees it.
  logic                 unused_w_slot;
  assign unused_w_slot = ^slots[DEPTH-1];

  assign in_slot = '{v:   hz.IssueD & hz.RegWriteD,
                     wa:  REG_W_MAX'(hz.WA3D),
                     rdy: SEL_W_MAX'(hz.ReadyD)};

  hazard_tag_pipe #(.DEPTH(DEPTH)) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush_e),
    .in_slot (in_slot),
    .slots   (slots)
  );

  // Per-operand youngest-writer search: forward when ready, else flag a hazard.
  // NOTE: every variable driven here gets a default before the loop so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    logic [DEPTH_MAX-1:0] hit;
    logic [SEL_W_MAX-1:0] k_match;
    logic [SEL_W_MAX-1:0] m_rdy;
    logic [SEL_W_MAX-1:0] src_slot;
    hazard   = '0;
    fwd      = '0;
    hit      = '0;
    k_match  = '0;
    m_rdy    = '0;
    src_slot = '0;
    for (int s = 0; s < NSRC; s++) begin
      hit = '0;
      for (int k = 0; k < DEPTH - 1; k++) begin
        hit[k] = slots[k].v && (slots[k].wa == REG_W_MAX'(hz.RAD[s*REGW +: REGW]));
      end
      k_match = youngest_match(hit);
      m_rdy   = '0;
      for (int k = 0; k < DEPTH - 1; k++) begin
        if (k_match == SEL_W_MAX'(k + 1)) m_rdy = slots[k].rdy;
      end
      // Value produced by slot k is visible at slot k+1's output next cycle.
      src_slot = k_match + SEL_W_MAX'(1);
      if (hz.RAUseD[s] && (k_match != '0)) begin
        if (src_slot >= m_rdy) fwd[s*SELW +: SELW] = SELW'(src_slot);
        else                   hazard[s] = 1'b1;
      end
    end
  end

  // A taken branch squashes decode anyway, so it overrides the load stall.
  assign load_stall    = (|hazard) & ~hz.BranchTakenE;
  assign flush_e       = load_stall | hz.BranchTakenE;
  assign hz.StallF     = load_stall;
  assign hz.StallD     = load_stall;
  assign hz.FlushE     = flush_e;
  assign hz.FlushD     = hz.BranchTakenE | hz.PCSrcW;
  assign hz.ForwardE   = forward_q;
  assign hz.StallCount = stall_count_q;

  // Forward selects travel with the instruction into E; a bubble carries none.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       forward_q <= '0;
    else if (flush_e) forward_q <= {NSRC{SELW'(FWD_RF)}};
    else              forward_q <= fwd;
  end

  // Saturating count of load-use stall cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_q <= '0;
    end else if (load_stall && (stall_count_q != {CW{1'b1}})) begin
      stall_count_q <= stall_count_q + CW'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard. The stimulus process drives one
// decode cycle at a time, predicts the response from a list of earlier
// instructions ordered by age, and queues the prediction; a monitor samples
// the DUT on the falling edge and compares against the queue head.
module tb_hazard_scoreboard;
  import hazard_pkg::*;

  localparam int NREG = 16;
  localparam int DEPTH = 3;
  localparam int NSRC = 2;
  localparam int CW = 4;
  localparam int REGW = $clog2(NREG);
  localparam int SELW = $clog2(DEPTH + 1);
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b0;

  hazard_scoreboard_if #(.NREG(NREG), .DEPTH(DEPTH), .NSRC(NSRC), .CW(CW)) bus ();

  hazard_scoreboard #(.NREG(NREG), .DEPTH(DEPTH), .NSRC(NSRC), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                 sf;
    logic                 sd;
    logic                 fd;
    logic                 fe;
    logic [NSRC*SELW-1:0] fwd;
    logic [CW-1:0]        cnt;
  } exp_t;

  // An earlier instruction that entered E: did it write, where, when ready.
  typedef struct {
    bit v;
    int wa;
    int rdy;
  } ent_t;

  exp_t exp_q[$];
  ent_t older[DEPTH];   // older[d-1] = instruction d cycles ahead of decode
  int   m_fwd[NSRC];
  int   m_cnt;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One decode cycle. Called at posedge+1; returns at the next posedge+1.
  task automatic step(input bit rst_n, input bit iss, input bit rw, input int wa,
                      input int rdy, input int ra0, input int ra1, input bit u0,
                      input bit u1, input bit bt, input bit pc);
    int   ra[NSRC];
    bit   rd_use[NSRC];
    int   nf[NSRC];
    bit   haz;
    bit   ls;
    bit   fe;
    exp_t e;
    ra[0] = ra0; ra[1] = ra1;
    rd_use[0] = u0; rd_use[1] = u1;

    reset            = rst_n;
    bus.IssueD       = iss;
    bus.RegWriteD    = rw;
    bus.WA3D         = REGW'(wa);
    bus.ReadyD       = SELW'(rdy);
    bus.RAD          = {REGW'(ra1), REGW'(ra0)};
    bus.RAUseD       = {u1, u0};
    bus.BranchTakenE = bt;
    bus.PCSrcW       = pc;

    if (!rst_n) begin
      for (int d = 0; d < DEPTH; d++) older[d] = '{v: 0, wa: 0, rdy: 0};
      for (int s = 0; s < NSRC; s++) m_fwd[s] = 0;
      m_cnt = 0;
    end

    // The nearest earlier writer of the register decides; the writeback
    // stage (distance DEPTH) is already visible in the register file.
    haz = 0;
    for (int s = 0; s < NSRC; s++) begin
      nf[s] = 0;
      if (rd_use[s]) begin
        for (int d = 1; d < DEPTH; d++) begin
          if (older[d-1].v && older[d-1].wa == ra[s]) begin
            if (d + 1 >= older[d-1].rdy) nf[s] = d + 1;
            else haz = 1;
            break;
          end
        end
      end
    end
    ls = haz && !bt;
    fe = ls || bt;

    e.sf  = ls;
    e.sd  = ls;
    e.fd  = bt || pc;
    e.fe  = fe;
    e.fwd = '0;
    for (int s = 0; s < NSRC; s++) e.fwd[s*SELW +: SELW] = SELW'(m_fwd[s]);
    e.cnt = CW'(m_cnt);
    exp_q.push_back(e);

    @(posedge clk);
    if (rst_n) begin
      for (int s = 0; s < NSRC; s++) m_fwd[s] = fe ? 0 : nf[s];
      if (ls && m_cnt < CNT_MAX) m_cnt++;
      for (int d = DEPTH - 1; d > 0; d--) older[d] = older[d-1];
      older[0] = '{v: iss && rw && !fe, wa: wa, rdy: rdy};
    end
    #1;
  endtask

  task automatic nop();
    step(1, 0, 0, 0, RDY_ALU, 0, 0, 0, 0, 0, 0);
  endtask

  // Writer of register wa with the given ready slot, optionally reading ra.
  task automatic wr(input int wa, input int rdy, input int ra, input bit u);
    step(1, 1, 1, wa, rdy, ra, 0, u, 0, 0, 0);
  endtask

  // Non-writing reader of register ra on operand 0.
  task automatic rd(input int ra);
    step(1, 1, 0, 0, RDY_ALU, ra, 0, 1, 0, 0, 0);
  endtask

  // Monitor: compare every DUT output against the queued prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("StallF",     32'(bus.StallF),     32'(e.sf));
        check("StallD",     32'(bus.StallD),     32'(e.sd));
        check("FlushD",     32'(bus.FlushD),     32'(e.fd));
        check("FlushE",     32'(bus.FlushE),     32'(e.fe));
        check("ForwardE",   32'(bus.ForwardE),   32'(e.fwd));
        check("StallCount", 32'(bus.StallCount), 32'(e.cnt));
      end
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, RDY_ALU, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, RDY_ALU, 0, 0, 0, 0, 0, 0);

    // Back-to-back ALU: R1 forwarded from slot 2 for one E cycle.
    wr(1, RDY_ALU, 0, 0); rd(1); nop(); nop(); nop();
    // Load-use: one stall cycle, decode held, then forwarded from slot 3.
    wr(2, RDY_LOAD, 0, 0); rd(2); rd(2); nop(); nop(); nop();
    // Load at distance 2: no stall.
    wr(3, RDY_LOAD, 0, 0); nop(); rd(3); nop(); nop(); nop();
    // Two writers of R4: the younger (slot 1) wins.
    wr(4, RDY_ALU, 0, 0); wr(4, RDY_ALU, 0, 0); rd(4); nop(); nop(); nop();
    // Matching register not read on operand 1: no stall.
    wr(9, RDY_LOAD, 0, 0); step(1, 1, 0, 0, RDY_ALU, 0, 9, 0, 0, 0, 0); nop(); nop();
    // Taken branch in the hazard cycle overrides the stall.
    wr(2, RDY_LOAD, 0, 0); step(1, 1, 0, 0, RDY_ALU, 2, 0, 1, 0, 1, 0); nop(); nop(); nop();
    // PCSrcW alone flushes decode only.
    step(1, 0, 0, 0, RDY_ALU, 0, 0, 0, 0, 0, 1); nop();

    // Reset with three pending writers discards them.
    wr(6, RDY_LOAD, 0, 0); wr(7, RDY_LOAD, 0, 0); wr(8, RDY_LOAD, 0, 0);
    step(0, 0, 0, 0, RDY_ALU, 0, 0, 0, 0, 0, 0);
    check("reset_forward", 32'(bus.ForwardE), 32'd0);
    check("reset_count",   32'(bus.StallCount), 32'd0);
    rd(8); nop(); nop();

    // Twenty load-use stalls saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      wr(5, RDY_LOAD, 0, 0); rd(5); rd(5);
    end
    nop();
    check("sat_count", 32'(bus.StallCount), 32'(CNT_MAX));

    // Random traffic on a small register set for frequent collisions.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 1) == 1,
           int'($urandom_range(0, 3)),
           int'($urandom_range(1, DEPTH)),
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0);
    end
    nop();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
